// File: rtl/camera_pkg.sv
// Shared defaults and FSM state encoding for the camera capture slice.
package camera_pkg;

  localparam int unsigned DEF_DATA_W        = 8;
  localparam int unsigned DEF_BYTES_PER_PIX = 2;
  localparam int unsigned DEF_MAX_COLS      = 640;
  localparam int unsigned DEF_MAX_ROWS      = 480;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_CAPTURE    = 2'd2
  } cam_state_t;

endpackage

// File: rtl/pixel_packer.sv
// Shifts camera bytes into a pixel word and strobes it when BYTES_PER_PIX bytes have arrived.
module pixel_packer
  import camera_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned BYTES_PER_PIX = DEF_BYTES_PER_PIX
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_clear,
  input  logic                            i_flush,
  input  logic                            i_en,
  input  logic [DATA_W-1:0]               i_data,
  output logic                            o_pix_valid,
  output logic [DATA_W*BYTES_PER_PIX-1:0] o_pix_data,
  output logic                            o_last,
  output logic                            o_phase_nz
);

  localparam int unsigned PIX_W = DATA_W * BYTES_PER_PIX;
  localparam int unsigned PH_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;

  logic [PH_W-1:0]  r_phase;
  logic [PIX_W-1:0] r_shift;
  logic [PIX_W-1:0] r_pix_data;
  logic             r_pix_valid;
  logic [PIX_W-1:0] w_shift_next;
  logic             w_last;

  // The oldest byte ends up in the MSBs once the word is full.
  always_comb begin
    w_shift_next              = r_shift << DATA_W;
    w_shift_next[DATA_W-1:0]  = i_data;
  end

  assign w_last = i_en && (r_phase == PH_W'(BYTES_PER_PIX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase     <= '0;
      r_shift     <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_pix_valid <= 1'b0;
      if (i_clear || i_flush) begin
        r_phase <= '0;
      end else if (i_en) begin
        r_shift <= w_shift_next;
        if (w_last) begin
          r_phase     <= '0;
          r_pix_valid <= 1'b1;
          r_pix_data  <= w_shift_next;
        end else begin
          r_phase <= r_phase + PH_W'(1);
        end
      end
    end
  end

  assign o_pix_valid = r_pix_valid;
  assign o_pix_data  = r_pix_data;
  assign o_last      = w_last;
  assign o_phase_nz  = (r_phase != '0);

endmodule

// File: rtl/camera_capture.sv
// Camera DVP capture: registers the camera bus, frames capture with an FSM and packs bytes into pixels.
module camera_capture
  import camera_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned BYTES_PER_PIX = DEF_BYTES_PER_PIX,
  parameter int unsigned MAX_COLS      = DEF_MAX_COLS,
  parameter int unsigned MAX_ROWS      = DEF_MAX_ROWS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cam_href,
  input  logic                            cam_vsync,
  input  logic [DATA_W-1:0]               cam_data,
  input  logic                            switch_shutter,
  input  logic                            continuous,
  output logic                            pix_valid,
  output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data,
  output logic                            pix_sof,
  output logic                            line_done,
  output logic                            frame_done,
  output logic                            busy,
  output logic [$clog2(MAX_ROWS+1)-1:0]   row_cnt,
  output logic [$clog2(MAX_COLS+1)-1:0]   col_cnt,
  output logic                            align_err
);

  localparam int unsigned ROW_W = $clog2(MAX_ROWS + 1);
  localparam int unsigned COL_W = $clog2(MAX_COLS + 1);

  logic              r_href, r_href_d, r_vsync, r_vsync_d;
  logic [DATA_W-1:0] r_data;
  logic              r_sh_meta, r_sh_sync, r_sh_d;
  cam_state_t        r_state, w_state_next;
  logic [ROW_W-1:0]  r_row_cnt;
  logic [COL_W-1:0]  r_col_cnt;
  logic              r_line_done, r_frame_done, r_align_err, r_sof_pend;

  logic w_href_fall, w_vsync_fall, w_vsync_rise, w_shutter_rise;
  logic w_capture, w_start_frame, w_row_end, w_frame_end;
  logic w_pix_valid, w_last, w_phase_nz;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_href    <= 1'b0;
      r_href_d  <= 1'b0;
      r_vsync   <= 1'b0;
      r_vsync_d <= 1'b0;
      r_data    <= '0;
      r_sh_meta <= 1'b0;
      r_sh_sync <= 1'b0;
      r_sh_d    <= 1'b0;
    end else begin
      r_href    <= cam_href;
      r_href_d  <= r_href;
      r_vsync   <= cam_vsync;
      r_vsync_d <= r_vsync;
      r_data    <= cam_data;
      r_sh_meta <= switch_shutter;
      r_sh_sync <= r_sh_meta;
      r_sh_d    <= r_sh_sync;
    end
  end

  assign w_href_fall    = r_href_d & ~r_href;
  assign w_vsync_fall   = r_vsync_d & ~r_vsync;
  assign w_vsync_rise   = ~r_vsync_d & r_vsync;
  assign w_shutter_rise = r_sh_sync & ~r_sh_d;

  assign w_capture     = (r_state == ST_CAPTURE);
  assign w_start_frame = (r_state == ST_WAIT_FRAME) && w_vsync_fall;
  assign w_row_end     = w_capture && w_href_fall;
  assign w_frame_end   = w_capture && w_vsync_rise;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Shutter edges are only consulted in IDLE, so edges elsewhere are simply dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:       if (continuous || w_shutter_rise) w_state_next = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (w_vsync_fall) w_state_next = ST_CAPTURE;
      ST_CAPTURE:    if (w_vsync_rise) w_state_next = continuous ? ST_WAIT_FRAME : ST_IDLE;
      default:       w_state_next = ST_IDLE;
    endcase
  end

  pixel_packer #(
    .DATA_W        (DATA_W),
    .BYTES_PER_PIX (BYTES_PER_PIX)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_start_frame),
    .i_flush     (w_row_end),
    .i_en        (w_capture && r_href),
    .i_data      (r_data),
    .o_pix_valid (w_pix_valid),
    .o_pix_data  (pix_data),
    .o_last      (w_last),
    .o_phase_nz  (w_phase_nz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_cnt    <= '0;
      r_col_cnt    <= '0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_align_err  <= 1'b0;
      r_sof_pend   <= 1'b0;
    end else begin
      r_line_done  <= w_row_end;
      r_frame_done <= w_frame_end;
      if (w_start_frame) begin
        r_row_cnt  <= '0;
        r_col_cnt  <= '0;
        r_sof_pend <= 1'b1;
      end else begin
        if (w_pix_valid) r_sof_pend <= 1'b0;
        if (w_row_end) begin
          r_col_cnt <= '0;
          if (r_row_cnt < ROW_W'(MAX_ROWS)) r_row_cnt <= r_row_cnt + ROW_W'(1);
          if (w_phase_nz) r_align_err <= 1'b1;
        end else if (w_last && (r_col_cnt < COL_W'(MAX_COLS))) begin
          r_col_cnt <= r_col_cnt + COL_W'(1);
        end
      end
    end
  end

  assign pix_valid  = w_pix_valid;
  assign pix_sof    = w_pix_valid & r_sof_pend;
  assign line_done  = r_line_done;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != ST_IDLE);
  assign row_cnt    = r_row_cnt;
  assign col_cnt    = r_col_cnt;
  assign align_err  = r_align_err;

endmodule

// File: tb/tb_camera_capture.sv
// Scoreboard bench driving a 2-byte and a 3-byte camera_capture instance from the same camera bus.
module tb_camera_capture;

  logic        clk = 1'b0;
  logic        reset, cam_href, cam_vsync, switch_shutter, continuous;
  logic [7:0]  cam_data;

  logic        pv2, sof2, ld2, fd2, busy2, err2;
  logic [15:0] pd2;
  logic [8:0]  row2;
  logic [9:0]  col2;
  logic        pv3, sof3, ld3, fd3, busy3, err3;
  logic [23:0] pd3;
  logic [8:0]  row3;
  logic [9:0]  col3;

  camera_capture dut (
    .clk(clk), .reset(reset), .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_data(cam_data),
    .switch_shutter(switch_shutter), .continuous(continuous),
    .pix_valid(pv2), .pix_data(pd2), .pix_sof(sof2), .line_done(ld2), .frame_done(fd2),
    .busy(busy2), .row_cnt(row2), .col_cnt(col2), .align_err(err2)
  );

  camera_capture #(.BYTES_PER_PIX(3)) dut3 (
    .clk(clk), .reset(reset), .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_data(cam_data),
    .switch_shutter(switch_shutter), .continuous(continuous),
    .pix_valid(pv3), .pix_data(pd3), .pix_sof(sof3), .line_done(ld3), .frame_done(fd3),
    .busy(busy3), .row_cnt(row3), .col_cnt(col3), .align_err(err3)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    logic        sof;
    int          row;
    int          col;
  } exp_t;

  exp_t q2[$], q3[$];
  exp_t e2m, e3m, ent;
  int   n_checks = 0, n_fail = 0;
  int   ph2, ph3, rowi, col2i, col3i;
  logic [31:0] sh2, sh3;
  bit   first2, first3, aerr2, aerr3, exp_cap, mon_busy, busy_drop;
  int   exp_lines, exp_frames, got_lines, got_frames, fd_rows;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    q2.delete(); q3.delete();
    ph2 = 0; ph3 = 0; sh2 = '0; sh3 = '0; rowi = 0; col2i = 0; col3i = 0;
    aerr2 = 0; aerr3 = 0; exp_lines = 0; exp_frames = 0; got_lines = 0; got_frames = 0;
  endtask

  task automatic model_frame_start();
    ph2 = 0; ph3 = 0; first2 = 1; first3 = 1; rowi = 0; col2i = 0; col3i = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    sh2 = {sh2[23:0], b}; sh3 = {sh3[23:0], b};
    ph2++; ph3++;
    if (ph2 == 2) begin
      col2i++;
      ent.data = {16'h0, sh2[15:0]}; ent.cyc = cyc + 2; ent.sof = first2; ent.row = rowi; ent.col = col2i;
      q2.push_back(ent);
      first2 = 0; ph2 = 0;
    end
    if (ph3 == 3) begin
      col3i++;
      ent.data = {8'h0, sh3[23:0]}; ent.cyc = cyc + 2; ent.sof = first3; ent.row = rowi; ent.col = col3i;
      q3.push_back(ent);
      first3 = 0; ph3 = 0;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    cam_href = 1'b1;
    cam_data = b;
    if (exp_cap) model_byte(b);
  endtask

  task automatic end_row(input int gap, input bit vs);
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = '0;
    if (vs) cam_vsync = 1'b1;
    if (exp_cap) begin
      if (ph2 != 0) aerr2 = 1;
      if (ph3 != 0) aerr3 = 1;
      ph2 = 0; ph3 = 0; col2i = 0; col3i = 0; rowi++; exp_lines++;
      if (vs) exp_frames++;
    end
    tick(gap - 1);
  endtask

  task automatic send_frame(input int rows, input int bpr, input int first_bpr,
                            input logic [7:0] start, input logic [7:0] step, input bit simul);
    logic [7:0] b;
    b = start;
    @(negedge clk);
    cam_vsync = 1'b0;
    model_frame_start();
    tick(3);
    for (int r = 0; r < rows; r++) begin
      for (int k = 0; k < ((r == 0) ? first_bpr : bpr); k++) begin
        drive_byte(b);
        b = b + step;
      end
      if (simul && (r == rows - 1)) end_row(4, 1'b1);
      else                          end_row(3, 1'b0);
    end
    if (!simul) begin
      @(negedge clk);
      cam_vsync = 1'b1;
      if (exp_cap) exp_frames++;
      tick(4);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cam_href = 1'b0;
    tick(3);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic shutter_pulse();
    @(negedge clk);
    switch_shutter = 1'b1;
    tick(4);
    switch_shutter = 1'b0;
    tick(2);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20 && !busy2; i++) @(negedge clk);
    check_val("busy_up", busy2, 1);
  endtask

  task automatic finish_test(input string name);
    tick(6);
    check_val({name, "_lines"}, got_lines, exp_lines);
    check_val({name, "_frames"}, got_frames, exp_frames);
    check_val({name, "_q2_left"}, q2.size(), 0);
    check_val({name, "_q3_left"}, q3.size(), 0);
    check_val({name, "_aerr2"}, err2, aerr2);
    check_val({name, "_aerr3"}, err3, aerr3);
  endtask

  always @(negedge clk) begin
    if (pv2) begin
      if (q2.size() == 0) check_val("pix2_unexpected", 1, 0);
      else begin
        e2m = q2.pop_front();
        check_val("pix2_data", pd2, e2m.data);
        check_val("pix2_latency", cyc, e2m.cyc);
        check_val("pix2_sof", sof2, e2m.sof);
        check_val("pix2_row", row2, e2m.row);
        check_val("pix2_col", col2, e2m.col);
      end
    end else if (sof2) check_val("sof2_alone", 1, 0);
    if (pv3) begin
      if (q3.size() == 0) check_val("pix3_unexpected", 1, 0);
      else begin
        e3m = q3.pop_front();
        check_val("pix3_data", pd3, e3m.data);
        check_val("pix3_latency", cyc, e3m.cyc);
        check_val("pix3_sof", sof3, e3m.sof);
        check_val("pix3_col", col3, e3m.col);
      end
    end else if (sof3) check_val("sof3_alone", 1, 0);
    if (ld2) got_lines++;
    if (fd2) begin
      got_frames++;
      check_val("frame_done_rows", row2, fd_rows);
    end
    if ((ld3 !== ld2) || (fd3 !== fd2)) check_val("dut3_pulses", {ld3, fd3}, {ld2, fd2});
    if (mon_busy && !busy2) busy_drop = 1;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cam_href = 1'b0; cam_vsync = 1'b1; cam_data = '0;
    switch_shutter = 1'b0; continuous = 1'b0;
    exp_cap = 0; mon_busy = 0; busy_drop = 0; fd_rows = 0;
    first2 = 0; first3 = 0;
    model_clear();
    tick(3);
    reset = 1'b0;
    tick(3);

    check_val("rst_pix_valid", pv2, 0);
    check_val("rst_pix_data", pd2, 0);
    check_val("rst_busy", busy2, 0);
    check_val("rst_row", row2, 0);
    check_val("rst_col", col2, 0);
    check_val("rst_align", err2, 0);
    check_val("rst_line_done", ld2, 0);
    check_val("rst_frame_done", fd2, 0);
    check_val("rst_busy3", busy3, 0);

    // Single shot: one captured frame, then a further frame is ignored.
    continuous = 1'b0;
    shutter_pulse();
    wait_busy();
    exp_cap = 1; fd_rows = 4;
    send_frame(4, 6, 6, 8'h12, 8'h22, 0);
    tick(4);
    check_val("t1_idle", busy2, 0);
    exp_cap = 0;
    send_frame(2, 6, 6, 8'h01, 8'h01, 0);
    finish_test("t1");

    // Continuous: three back-to-back frames, last with coincident href fall / vsync rise.
    do_reset();
    continuous = 1'b1;
    tick(3);
    check_val("t2_busy", busy2, 1);
    mon_busy = 1; exp_cap = 1; fd_rows = 4;
    send_frame(4, 4, 4, 8'h40, 8'h03, 0);
    send_frame(4, 4, 4, 8'h80, 8'h05, 0);
    send_frame(4, 4, 4, 8'hC0, 8'h07, 1);
    mon_busy = 0;
    check_val("t2_busy_drop", busy_drop, 0);
    finish_test("t2");

    // Partial pixel at row end sets a sticky alignment error.
    do_reset();
    continuous = 1'b1;
    tick(3);
    exp_cap = 1; fd_rows = 3;
    send_frame(3, 4, 5, 8'h21, 8'h01, 0);
    check_val("t3_err_set", err2, 1);
    fd_rows = 1;
    send_frame(1, 6, 6, 8'h31, 8'h01, 0);
    finish_test("t3");
    do_reset();
    tick(2);
    check_val("t3_err_cleared", err2, 0);
    check_val("t3_err3_cleared", err3, 0);

    // Reset mid-row while href is high; capture resumes only after a fresh vsync fall.
    continuous = 1'b1;
    tick(3);
    exp_cap = 1;
    @(negedge clk);
    cam_vsync = 1'b0;
    model_frame_start();
    tick(3);
    drive_byte(8'h51);
    exp_cap = 0;
    @(negedge clk); reset = 1'b1; cam_data = 8'h52;
    @(negedge clk); cam_data = 8'h53;
    @(negedge clk); reset = 1'b0; cam_data = 8'h54;
    model_clear();
    for (int k = 0; k < 4; k++) drive_byte(8'h55 + 8'(k));
    end_row(3, 0);
    for (int k = 0; k < 4; k++) drive_byte(8'h5A + 8'(k));
    end_row(3, 0);
    @(negedge clk);
    cam_vsync = 1'b1;
    tick(4);
    check_val("t4_no_lines", got_lines, 0);
    exp_cap = 1; fd_rows = 2;
    send_frame(2, 4, 4, 8'h61, 8'h01, 0);
    finish_test("t4");

    // Shutter during capture is not queued; 0xAA,0xBB,0xCC gives 0xAABBCC on the 3-byte instance.
    do_reset();
    continuous = 1'b0;
    tick(2);
    shutter_pulse();
    wait_busy();
    exp_cap = 1; fd_rows = 2;
    fork
      begin
        tick(8);
        switch_shutter = 1'b1;
        tick(4);
        switch_shutter = 1'b0;
      end
    join_none
    send_frame(2, 6, 6, 8'hAA, 8'h11, 0);
    tick(4);
    check_val("t5_idle", busy2, 0);
    exp_cap = 0;
    send_frame(2, 6, 6, 8'h70, 8'h01, 0);
    check_val("t5_still_idle", busy2, 0);
    finish_test("t5");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
